// File: rtl/ram512_dma_if.sv
// Bundles the DMA control handshake and the RAM512-style memory port into one interface.
// The master modport is the DMA engine; the slave side is the system plus the RAM.
interface ram512_dma_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] pattern;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [DATA_W-1:0] mem_out;

    modport master (
        input  start, mode, src, dst, len, pattern, mem_out,
        output busy, done, mem_address, mem_in, mem_load
    );

    modport slave (
        output start, mode, src, dst, len, pattern, mem_out,
        input  busy, done, mem_address, mem_in, mem_load
    );
endinterface

// File: rtl/ram512_dma.sv
// Block copy / block fill engine driving a RAM512-style port (address, in, load, comb out).
// One word per READ+WRITE pair for copy, one word per WRITE for fill, strictly ascending.
module ram512_dma #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    ram512_dma_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] AddrOne  = 1;
    localparam logic [ADDR_W:0]   CountOne = 1;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_src_cur;
    logic [ADDR_W-1:0] r_dst_cur;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_hold;
    logic              r_mode;
    logic [DATA_W-1:0] r_pattern;

    logic              w_busy;
    logic              w_done;
    logic              w_load;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_last;

    assign w_last = ((r_count + CountOne) == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs decode only registered state/pointers, so start never reaches mem_* combinationally.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        w_state_next = StDone;
                    end else if (bus.mode) begin
                        w_state_next = StWrite;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StRead: begin
                w_busy       = 1'b1;
                w_addr       = r_src_cur;
                w_state_next = StWrite;
            end
            StWrite: begin
                w_busy  = 1'b1;
                w_load  = 1'b1;
                w_addr  = r_dst_cur;
                w_wdata = r_mode ? r_pattern : r_hold;
                if (w_last) begin
                    w_state_next = StDone;
                end else if (r_mode) begin
                    w_state_next = StWrite;
                end else begin
                    w_state_next = StRead;
                end
            end
            StDone: begin
                w_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src_cur <= '0;
            r_dst_cur <= '0;
            r_count   <= '0;
            r_len     <= '0;
            r_hold    <= '0;
            r_mode    <= 1'b0;
            r_pattern <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_src_cur <= bus.src;
                        r_dst_cur <= bus.dst;
                        r_len     <= bus.len;
                        r_mode    <= bus.mode;
                        r_pattern <= bus.pattern;
                        r_count   <= '0;
                    end
                end
                StRead: begin
                    r_hold <= bus.mem_out;
                end
                StWrite: begin
                    // Pointers wrap naturally at 2**ADDR_W.
                    r_count   <= r_count + CountOne;
                    r_src_cur <= r_src_cur + AddrOne;
                    r_dst_cur <= r_dst_cur + AddrOne;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.mem_load    = w_load;
    assign bus.mem_address = w_addr;
    assign bus.mem_in      = w_wdata;

endmodule
